// File: rtl/usr_shift_ctrl.sv
// ---------------------------------------------------------------------------
// usr_shift_ctrl
//
// Command sequencer for an external universal shift register. A command
// (load / shift / rotate / load-then-shift) is accepted over a valid/ready
// handshake, expanded into a sequence of register mode cycles, and the final
// register contents are returned over a second valid/ready handshake.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready     command handshake
//   cmd_op              000 LOAD, 001 SHR, 010 SHL, 011 ROR, 100 ROL,
//                       101 LOAD_SHR, 110 LOAD_SHL, 111 illegal
//   cmd_data            parallel load value
//   cmd_count           number of shift/rotate steps (0..7)
//   cmd_fill            serial bit for shifts
//   usr_select          register mode: 00 hold, 01 right, 10 left, 11 load
//   usr_p_din           parallel data to the register
//   usr_s_left_din      serial input entering the LSB on a left shift
//   usr_s_right_din     serial input entering the MSB on a right shift
//   usr_p_dout          register parallel output
//   rsp_valid/ready     response handshake
//   rsp_data, rsp_err   result word and illegal-op flag
//   busy                high whenever not idle
// ---------------------------------------------------------------------------
module usr_shift_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [2:0]       cmd_count,
    input  logic             cmd_fill,
    output logic [1:0]       usr_select,
    output logic [WIDTH-1:0] usr_p_din,
    output logic             usr_s_left_din,
    output logic             usr_s_right_din,
    input  logic [WIDTH-1:0] usr_p_dout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD     = 3'd0,
        OP_SHR      = 3'd1,
        OP_SHL      = 3'd2,
        OP_ROR      = 3'd3,
        OP_ROL      = 3'd4,
        OP_LOAD_SHR = 3'd5,
        OP_LOAD_SHL = 3'd6,
        OP_ILLEGAL  = 3'd7
    } op_t;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    state_t           state, state_next;
    op_t              op_q;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       cnt_q;
    logic             fill_q;
    logic             err_q;
    logic             resp_first;
    logic [WIDTH-1:0] rsp_hold;

    logic accept;
    op_t  cmd_op_e;
    logic shift_right;
    logic load_then_shift;

    assign cmd_op_e        = op_t'(cmd_op);
    assign accept          = cmd_valid && cmd_ready;
    assign shift_right     = (op_q == OP_SHR) || (op_q == OP_ROR) || (op_q == OP_LOAD_SHR);
    assign load_then_shift = (op_q == OP_LOAD_SHR) || (op_q == OP_LOAD_SHL);

    // Gating with rst_n keeps cmd_ready low for the whole reset pulse.
    assign cmd_ready = rst_n && (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = (state == RESP) && err_q;

    // The last shift lands on the same edge that enters RESP, so the result
    // is only visible during the first RESP cycle; pass it through then and
    // hold the captured copy afterwards.
    assign rsp_data = (state != RESP) ? '0 :
                      (resp_first ? usr_p_dout : rsp_hold);

    // State register and captured command fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= OP_LOAD;
            data_q     <= '0;
            cnt_q      <= '0;
            fill_q     <= 1'b0;
            err_q      <= 1'b0;
            resp_first <= 1'b0;
            rsp_hold   <= '0;
        end else begin
            state      <= state_next;
            resp_first <= (state != RESP) && (state_next == RESP);
            if (resp_first) begin
                rsp_hold <= usr_p_dout;
            end
            if (accept) begin
                op_q   <= cmd_op_e;
                data_q <= cmd_data;
                cnt_q  <= cmd_count;
                fill_q <= cmd_fill;
                err_q  <= (cmd_op_e == OP_ILLEGAL);
            end else if (state == SHIFT) begin
                cnt_q <= cnt_q - 3'd1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (cmd_op_e)
                        OP_LOAD, OP_LOAD_SHR, OP_LOAD_SHL: state_next = LOAD;
                        OP_ILLEGAL:                        state_next = RESP;
                        default: state_next = (cmd_count != 3'd0) ? SHIFT : RESP;
                    endcase
                end
            end
            LOAD: begin
                state_next = (load_then_shift && (cnt_q != 3'd0)) ? SHIFT : RESP;
            end
            SHIFT: begin
                // cnt_q holds the steps still to do, including this one.
                if (cnt_q == 3'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Register control outputs; everything rests at zero outside LOAD/SHIFT.
    always_comb begin
        usr_select      = SEL_HOLD;
        usr_p_din       = '0;
        usr_s_left_din  = 1'b0;
        usr_s_right_din = 1'b0;
        unique case (state)
            LOAD: begin
                usr_select = SEL_LOAD;
                usr_p_din  = data_q;
            end
            SHIFT: begin
                usr_select = shift_right ? SEL_RIGHT : SEL_LEFT;
                unique case (op_q)
                    OP_SHR, OP_LOAD_SHR: usr_s_right_din = fill_q;
                    OP_SHL, OP_LOAD_SHL: usr_s_left_din  = fill_q;
                    OP_ROR:              usr_s_right_din = usr_p_dout[0];
                    OP_ROL:              usr_s_left_din  = usr_p_dout[WIDTH-1];
                    default: begin
                        usr_s_left_din  = 1'b0;
                        usr_s_right_din = 1'b0;
                    end
                endcase
            end
            default: begin
                usr_select = SEL_HOLD;
            end
        endcase
    end

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// ---------------------------------------------------------------------------
// tb_usr_shift_ctrl
//
// Drives commands into usr_shift_ctrl, which controls a behavioural universal
// shift register living in this bench. Expected responses come from a
// word-level reference model and are queued; a monitor pops and compares
// them whenever a response appears.
// ---------------------------------------------------------------------------
module tb_usr_shift_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic [2:0]   cmd_count;
    logic         cmd_fill;
    logic [1:0]   usr_select;
    logic [W-1:0] usr_p_din;
    logic         usr_s_left_din;
    logic         usr_s_right_din;
    logic [W-1:0] usr_p_dout;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int data;
        int err;
        int lat;
        int nload;
        int nright;
        int nleft;
        int acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   model_val = 0;

    usr_shift_ctrl #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_data        (cmd_data),
        .cmd_count       (cmd_count),
        .cmd_fill        (cmd_fill),
        .usr_select      (usr_select),
        .usr_p_din       (usr_p_din),
        .usr_s_left_din  (usr_s_left_din),
        .usr_s_right_din (usr_s_right_din),
        .usr_p_dout      (usr_p_dout),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // The controlled universal shift register, cleared by reset.
    logic [W-1:0] reg_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q <= '0;
        end else begin
            case (usr_select)
                2'b01:   reg_q <= {usr_s_right_din, reg_q[W-1:1]};
                2'b10:   reg_q <= {reg_q[W-2:0], usr_s_left_din};
                2'b11:   reg_q <= usr_p_din;
                default: reg_q <= reg_q;
            endcase
        end
    end
    assign usr_p_dout = reg_q;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Word-level reference: what the register holds after the command, and
    // how many load / right / left cycles it should take.
    function automatic exp_t refModel(input int op, input int data, input int count,
                                      input int fill, input int cur);
        exp_t e;
        int   mask;
        int   v;
        int   r;
        mask     = (1 << W) - 1;
        v        = cur;
        r        = count % W;
        e.err    = 0;
        e.nload  = 0;
        e.nright = 0;
        e.nleft  = 0;
        e.acc_cyc = 0;
        if (op == 0 || op == 5 || op == 6) begin
            v       = data;
            e.nload = 1;
        end
        case (op)
            1, 5: begin
                for (int i = 0; i < count; i++) v = (v >> 1) | (fill << (W - 1));
                e.nright = count;
            end
            2, 6: begin
                for (int i = 0; i < count; i++) v = ((v << 1) | fill) & mask;
                e.nleft = count;
            end
            3: begin
                v = ((v >> r) | (v << (W - r))) & mask;
                e.nright = count;
            end
            4: begin
                v = ((v << r) | (v >> (W - r))) & mask;
                e.nleft = count;
            end
            7: e.err = 1;
            default: ;
        endcase
        e.data = v;
        e.lat  = 1 + e.nload + e.nright + e.nleft;
        return e;
    endfunction

    // Issue one command, queue its expectation, then drain its response.
    // hold > 0 keeps rsp_ready low for that many cycles of rsp_valid.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] data,
                                 input logic [2:0] count, input logic fill, input int hold);
        exp_t e;
        int   guard;
        int   held;
        bit   done;
        @(negedge clk);
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = count;
        cmd_fill  = fill;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            checkOutput("cmd_ready_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        e = refModel(int'(op), int'(data), int'(count), int'(fill), model_val);
        e.acc_cyc = cyc;
        model_val = e.data;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = W'($urandom);
        cmd_count = 3'($urandom);
        cmd_fill  = 1'($urandom);
        held  = 0;
        guard = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                done = 1'b1;
            end else begin
                if (rsp_valid) held++;
                guard++;
                if (guard > 200) begin
                    checkOutput("rsp_timeout", 0, 1);
                    done = 1'b1;
                end else begin
                    @(posedge clk);
                    #1;
                    rsp_ready = (held >= hold) ? ($urandom_range(0, 3) != 0) : 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    // Abort an SHR count 5 in its second shift cycle with an async reset.
    task automatic resetTest();
        @(negedge clk);
        checkOutput("rst_pre_ready", int'(cmd_ready), 1);
        cmd_op    = 3'b001;
        cmd_data  = '0;
        cmd_count = 3'd5;
        cmd_fill  = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_in_shift_sel", int'(usr_select), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_sel", int'(usr_select), 0);
        checkOutput("rst_async_busy", int'(busy), 0);
        checkOutput("rst_async_ready", int'(cmd_ready), 0);
        checkOutput("rst_async_sright", int'(usr_s_right_din), 0);
        model_val = 0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_release_ready", int'(cmd_ready), 1);
        repeat (8) begin
            @(negedge clk);
            checkOutput("rst_no_rsp", int'(rsp_valid), 0);
        end
    endtask

    // Scoreboard monitor: compares each response against the queue head and
    // checks that a stalled response stays stable.
    initial begin : monitor
        int   n_load  = 0;
        int   n_right = 0;
        int   n_left  = 0;
        bit   in_resp = 1'b0;
        bit   expect_idle = 1'b0;
        int   held_data = 0;
        int   held_err  = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                n_load = 0; n_right = 0; n_left = 0;
                in_resp = 1'b0;
                expect_idle = 1'b0;
                continue;
            end
            case (usr_select)
                2'b01:   n_right++;
                2'b10:   n_left++;
                2'b11:   n_load++;
                default: ;
            endcase
            if (rsp_valid) begin
                checkOutput("resp_select", int'(usr_select), 0);
                if (!in_resp) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_rsp", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("rsp_data", int'(rsp_data), e.data);
                        checkOutput("rsp_err", int'(rsp_err), e.err);
                        checkOutput("latency", cyc - e.acc_cyc, e.lat);
                        checkOutput("load_cycles", n_load, e.nload);
                        checkOutput("right_cycles", n_right, e.nright);
                        checkOutput("left_cycles", n_left, e.nleft);
                    end
                    n_load = 0; n_right = 0; n_left = 0;
                    held_data = int'(rsp_data);
                    held_err  = int'(rsp_err);
                    in_resp   = 1'b1;
                end else begin
                    checkOutput("rsp_data_stable", int'(rsp_data), held_data);
                    checkOutput("rsp_err_stable", int'(rsp_err), held_err);
                end
                if (rsp_ready) begin
                    in_resp     = 1'b0;
                    expect_idle = 1'b1;
                end
            end else if (expect_idle) begin
                checkOutput("idle_after_rsp", int'(cmd_ready), 1);
                expect_idle = 1'b0;
            end
        end
    end

    // Main sequence: reset, directed cases, reset abort, random commands.
    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        cmd_count = '0;
        cmd_fill  = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_select", int'(usr_select), 0);
        checkOutput("reset_p_din", int'(usr_p_din), 0);
        checkOutput("reset_s_left", int'(usr_s_left_din), 0);
        checkOutput("reset_s_right", int'(usr_s_right_din), 0);
        checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
        checkOutput("reset_rsp_err", int'(rsp_err), 0);
        checkOutput("reset_rsp_data", int'(rsp_data), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_cmd_ready", int'(cmd_ready), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release_cmd_ready", int'(cmd_ready), 1);

        applyStimulus(3'b101, 4'b1101, 3'd2, 1'b0, 0);  // LOAD_SHR -> 0011
        applyStimulus(3'b100, 4'b0000, 3'd1, 1'b0, 0);  // ROL 1    -> 0110
        applyStimulus(3'b010, 4'b0000, 3'd3, 1'b1, 5);  // SHL 3    -> 0111, stalled
        applyStimulus(3'b111, 4'b1010, 3'd4, 1'b1, 0);  // illegal  -> 0111, err
        applyStimulus(3'b001, 4'b0000, 3'd0, 1'b1, 0);  // SHR 0    -> unchanged
        applyStimulus(3'b000, 4'b1001, 3'd6, 1'b0, 0);  // LOAD ignores count
        applyStimulus(3'b011, 4'b0000, 3'd7, 1'b0, 0);  // ROR 7 == ROR 3
        applyStimulus(3'b110, 4'b0101, 3'd0, 1'b1, 0);  // LOAD_SHL count 0

        resetTest();

        for (int i = 0; i < 60; i++) begin
            applyStimulus(3'($urandom), W'($urandom), 3'($urandom), 1'($urandom),
                          ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usr_shift_ctrl.md
USR_SHIFT_CTRL -- requirements
Module: usr_shift_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: width of the controlled universal shift register's parallel port.
REQ-002 Port clk input 1: single clock; all state updates on rising edge.
REQ-003 Port rst_n input 1: reset, asynchronous and active-low.
REQ-004 Port cmd_valid input 1: command offered.
REQ-005 Port cmd_ready output 1: command accepted when cmd_valid and cmd_ready are both high on a rising edge.
REQ-006 Port cmd_op input 3: 000 LOAD, 001 SHR, 010 SHL, 011 ROR, 100 ROL, 101 LOAD_SHR, 110 LOAD_SHL, 111 illegal.
REQ-007 Port cmd_data input WIDTH: parallel load value.
REQ-008 Port cmd_count input 3: number of shift/rotate steps, 0..7.
REQ-009 Port cmd_fill input 1: serial bit inserted by SHR/SHL and the LOAD_ variants.
REQ-010 Port usr_select output 2: register mode; 00 hold, 01 shift right (s_right_din enters MSB), 10 shift left (s_left_din enters LSB), 11 parallel load.
REQ-011 Port usr_p_din output WIDTH: parallel data to register.
REQ-012 Port usr_s_left_din output 1 and usr_s_right_din output 1: serial inputs to register.
REQ-013 Port usr_p_dout input WIDTH: register parallel output.
REQ-014 Port rsp_valid output 1, rsp_ready input 1: response handshake.
REQ-015 Port rsp_data output WIDTH and rsp_err output 1: result word; illegal-op flag.
REQ-016 Port busy output 1: high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, SHIFT, RESP; cmd_ready high only in IDLE.
REQ-018 On acceptance, op, data, count and fill SHALL be captured; later cmd_* changes have no effect.
REQ-019 IDLE: LOAD/LOAD_SHR/LOAD_SHL -> LOAD; SHR/SHL/ROR/ROL with count>0 -> SHIFT; count=0 -> RESP; illegal -> RESP with rsp_err=1.
REQ-020 LOAD lasts exactly one cycle, usr_select=11, usr_p_din=captured data; then SHIFT if LOAD_ variant with count>0, else RESP.
REQ-021 SHIFT lasts exactly count cycles, usr_select=01 (SHR/ROR/LOAD_SHR) or 10 (SHL/ROL/LOAD_SHL), then RESP.
REQ-022 Shift fill: usr_s_right_din / usr_s_left_din = captured fill; rotate: usr_s_right_din = usr_p_dout[0] (ROR), usr_s_left_din = usr_p_dout[WIDTH-1] (ROL), combinational from usr_p_dout.
REQ-023 usr_select SHALL be 00 in IDLE and RESP; usr_p_din = 0 and serial inputs = 0 outside LOAD/SHIFT.
REQ-024 RESP: rsp_valid=1, rsp_data=usr_p_dout sampled on RESP entry and held stable; leave to IDLE on rsp_valid&&rsp_ready.
REQ-025 rsp_err SHALL be 1 only for op 111 and stay 0 otherwise; illegal op drives no LOAD/SHIFT cycle.
REQ-026 Latency accept->rsp_valid: 1 cycle + (1 if load) + count cycles.
REQ-027 count > WIDTH SHALL be honoured literally (e.g. 7 rotates of a 4-bit word = 3 rotates).
REQ-028 A new command SHALL not be accepted in the same cycle a response is consumed (one IDLE cycle minimum).

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, usr_select=00, usr_p_din=0, serial inputs 0, rsp_valid=0, rsp_err=0, rsp_data=0, busy=0, cmd_ready=0 while low, 1 after release.
REQ-030 Reset mid-LOAD/SHIFT/RESP SHALL abort the command with no response issued.

Verification
REQ-031 LOAD_SHR data 1101, count 2, fill 0 -> select 11,01,01; rsp_data 0011, latency 4, rsp_err 0.
REQ-032 Then ROL count 1 -> select 10 one cycle, usr_s_left_din=0; rsp_data 0110.
REQ-033 Then SHL count 3 fill 1 -> rsp_data 0111; rsp_ready held low 5 cycles keeps rsp_valid and rsp_data stable.
REQ-034 Op 111 -> no non-00 select, rsp_err=1, rsp_data = current usr_p_dout, latency 1.
REQ-035 SHR count 0 -> select stays 00, rsp_valid next cycle with unchanged data.
REQ-036 rst_n low during second SHIFT cycle of SHR count 5 -> select 00 asynchronously, no rsp_valid, cmd_ready 1 after release.
